// File: rtl/alu_bist_redundancy_ctrl.sv
// Periodic BIST scheduler and spare-pool manager for an array of identical ALUs.
// Tests the active unit while a healthy cover unit serves the pipeline; retires failing units.
module alu_bist_redundancy_ctrl #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned NUM_UNITS   = 2,
    parameter int unsigned NUM_VECTORS = 8,
    parameter int unsigned TEST_PERIOD = 65536,
    parameter int unsigned FAIL_THRESH = 1,
    localparam int unsigned VEC_W      = $clog2(NUM_VECTORS),
    localparam int unsigned SEL_W      = (NUM_UNITS > 2) ? $clog2(NUM_UNITS) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        test_req,
    input  logic [NUM_UNITS*DATA_W-1:0] unit_res,
    input  logic [NUM_UNITS-1:0]        unit_carry,
    input  logic [DATA_W-1:0]           exp_res,
    input  logic                        exp_carry,
    output logic                        test_en,
    output logic [VEC_W-1:0]            vec_idx,
    output logic [SEL_W-1:0]            active_sel,
    output logic [SEL_W-1:0]            out_sel,
    output logic                        stall_req,
    output logic [NUM_UNITS-1:0]        unit_failed,
    output logic                        fault_flag,
    output logic                        spares_exhausted
);

    localparam int unsigned TMR_W = $clog2(TEST_PERIOD);
    localparam int unsigned CNT_W = $clog2(FAIL_THRESH + 1);
    localparam logic [VEC_W-1:0] VecLast = VEC_W'(NUM_VECTORS - 1);
    localparam logic [TMR_W-1:0] TmrLast = TMR_W'(TEST_PERIOD - 1);

    typedef enum logic [1:0] {StIdle, StTest, StEval, StDead} state_e;

    state_e                 state_q, state_d;
    logic [TMR_W-1:0]       timer_q, timer_d;
    logic [VEC_W-1:0]       vec_q, vec_d;
    logic [SEL_W-1:0]       active_q, active_d;
    logic [CNT_W-1:0]       fail_cnt_q, fail_cnt_d;
    logic                   mismatch_q, mismatch_d;
    logic [NUM_UNITS-1:0]   failed_q, failed_d;

    logic [DATA_W-1:0]      act_res;
    logic                   act_carry;
    logic                   vec_miss;
    logic                   cover_ok;
    logic [SEL_W-1:0]       cover_sel;
    logic [NUM_UNITS-1:0]   failed_ret;
    logic                   promote_ok;
    logic [SEL_W-1:0]       promote_sel;

    always_comb begin
        act_res   = '0;
        act_carry = 1'b0;
        for (int i = 0; i < int'(NUM_UNITS); i++) begin
            if (SEL_W'(i) == active_q) begin
                act_res   = unit_res[i*DATA_W +: DATA_W];
                act_carry = unit_carry[i];
            end
        end
    end

    assign vec_miss   = (act_res != exp_res) | (act_carry != exp_carry);
    assign failed_ret = failed_q | (NUM_UNITS'(1) << active_q);

    // Descending scans so the lowest qualifying index is the one that sticks.
    always_comb begin
        cover_ok    = 1'b0;
        cover_sel   = '0;
        promote_ok  = 1'b0;
        promote_sel = '0;
        for (int i = int'(NUM_UNITS) - 1; i >= 0; i--) begin
            if (!failed_q[i] && (SEL_W'(i) != active_q)) begin
                cover_ok  = 1'b1;
                cover_sel = SEL_W'(i);
            end
            if (!failed_ret[i]) begin
                promote_ok  = 1'b1;
                promote_sel = SEL_W'(i);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        vec_d      = vec_q;
        active_d   = active_q;
        fail_cnt_d = fail_cnt_q;
        mismatch_d = mismatch_q;
        failed_d   = failed_q;
        unique case (state_q)
            StIdle: begin
                timer_d = timer_q + 1'b1;
                if (test_req || (timer_q == TmrLast)) begin
                    state_d    = StTest;
                    timer_d    = '0;
                    vec_d      = '0;
                    mismatch_d = 1'b0;
                end
            end
            StTest: begin
                mismatch_d = mismatch_q | vec_miss;
                if (vec_q == VecLast) begin
                    vec_d   = '0;
                    state_d = StEval;
                end else begin
                    vec_d = vec_q + 1'b1;
                end
            end
            StEval: begin
                if (!mismatch_q) begin
                    fail_cnt_d = '0;
                    state_d    = StIdle;
                end else if (int'(fail_cnt_q) + 1 < int'(FAIL_THRESH)) begin
                    fail_cnt_d = fail_cnt_q + 1'b1;
                    mismatch_d = 1'b0;
                    vec_d      = '0;
                    state_d    = StTest;
                end else begin
                    failed_d   = failed_ret;
                    fail_cnt_d = '0;
                    if (promote_ok) begin
                        active_d = promote_sel;
                        state_d  = StIdle;
                    end else begin
                        state_d = StDead;
                    end
                end
            end
            StDead: begin
                state_d = StDead;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            timer_q    <= '0;
            vec_q      <= '0;
            active_q   <= '0;
            fail_cnt_q <= '0;
            mismatch_q <= 1'b0;
            failed_q   <= '0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            vec_q      <= vec_d;
            active_q   <= active_d;
            fail_cnt_q <= fail_cnt_d;
            mismatch_q <= mismatch_d;
            failed_q   <= failed_d;
        end
    end

    // Pipeline steering is decoded from registered state only.
    always_comb begin
        out_sel   = active_q;
        stall_req = 1'b0;
        if ((state_q == StTest) || (state_q == StEval)) begin
            if (cover_ok) begin
                out_sel = cover_sel;
            end else begin
                stall_req = 1'b1;
            end
        end
    end

    assign test_en          = (state_q == StTest);
    assign vec_idx          = vec_q;
    assign active_sel       = active_q;
    assign unit_failed      = failed_q;
    assign fault_flag       = |failed_q;
    assign spares_exhausted = (state_q == StDead);

endmodule

// File: tb/tb_alu_bist_redundancy_ctrl.sv
// Directed bench: three controller instances (2 units/thresh 1, 2 units/thresh 2, 3 units)
// driven by a small ALU model whose per-unit faults are injected at chosen vectors.
module tb_alu_bist_redundancy_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [7:0] lut(input logic [2:0] v);
        return 8'(v) * 8'd37 + 8'd5;
    endfunction

    // mode 1 corrupts the result, mode 2 flips the carry, both only at vector cv.
    function automatic logic [8:0] unit_out(input logic [2:0] v, input logic [1:0] mode,
                                            input logic [2:0] cv);
        logic [8:0] r;
        r = {v[0], lut(v)};
        if (v == cv && mode == 2'd1) r[7:0] = r[7:0] ^ 8'h5A;
        if (v == cv && mode == 2'd2) r[8] = ~r[8];
        return r;
    endfunction

    // ---------------- instance A: 2 units, threshold 1 ----------------
    logic        test_req_a, test_en_a, stall_a, fault_a, spares_a;
    logic [15:0] unit_res_a;
    logic [1:0]  unit_carry_a, failed_a;
    logic [7:0]  exp_res_a;
    logic [2:0]  vec_a;
    logic        act_a, out_a;
    logic [1:0]  mode_a [2];
    logic [2:0]  cvec_a [2];

    always_comb begin
        unit_res_a   = '0;
        unit_carry_a = '0;
        for (int i = 0; i < 2; i++) begin
            {unit_carry_a[i], unit_res_a[i*8 +: 8]} = unit_out(vec_a, mode_a[i], cvec_a[i]);
        end
    end
    assign exp_res_a = lut(vec_a);

    alu_bist_redundancy_ctrl #(
        .DATA_W(8), .NUM_UNITS(2), .NUM_VECTORS(8), .TEST_PERIOD(16), .FAIL_THRESH(1)
    ) u_a (
        .clk(clk), .rst(rst), .test_req(test_req_a), .unit_res(unit_res_a),
        .unit_carry(unit_carry_a), .exp_res(exp_res_a), .exp_carry(vec_a[0]),
        .test_en(test_en_a), .vec_idx(vec_a), .active_sel(act_a), .out_sel(out_a),
        .stall_req(stall_a), .unit_failed(failed_a), .fault_flag(fault_a),
        .spares_exhausted(spares_a)
    );

    // ---------------- instance B: 2 units, threshold 2 ----------------
    logic        test_req_b, test_en_b, stall_b, fault_b, spares_b;
    logic [15:0] unit_res_b;
    logic [1:0]  unit_carry_b, failed_b;
    logic [7:0]  exp_res_b;
    logic [2:0]  vec_b;
    logic        act_b, out_b;
    logic [1:0]  mode_b [2];
    logic [2:0]  cvec_b [2];

    always_comb begin
        unit_res_b   = '0;
        unit_carry_b = '0;
        for (int i = 0; i < 2; i++) begin
            {unit_carry_b[i], unit_res_b[i*8 +: 8]} = unit_out(vec_b, mode_b[i], cvec_b[i]);
        end
    end
    assign exp_res_b = lut(vec_b);

    alu_bist_redundancy_ctrl #(
        .DATA_W(8), .NUM_UNITS(2), .NUM_VECTORS(8), .TEST_PERIOD(16), .FAIL_THRESH(2)
    ) u_b (
        .clk(clk), .rst(rst), .test_req(test_req_b), .unit_res(unit_res_b),
        .unit_carry(unit_carry_b), .exp_res(exp_res_b), .exp_carry(vec_b[0]),
        .test_en(test_en_b), .vec_idx(vec_b), .active_sel(act_b), .out_sel(out_b),
        .stall_req(stall_b), .unit_failed(failed_b), .fault_flag(fault_b),
        .spares_exhausted(spares_b)
    );

    // ---------------- instance C: 3 units, threshold 1 ----------------
    logic        test_req_c, test_en_c, stall_c, fault_c, spares_c;
    logic [23:0] unit_res_c;
    logic [2:0]  unit_carry_c, failed_c;
    logic [7:0]  exp_res_c;
    logic [2:0]  vec_c;
    logic [1:0]  act_c, out_c;
    logic [1:0]  mode_c [3];
    logic [2:0]  cvec_c [3];

    always_comb begin
        unit_res_c   = '0;
        unit_carry_c = '0;
        for (int i = 0; i < 3; i++) begin
            {unit_carry_c[i], unit_res_c[i*8 +: 8]} = unit_out(vec_c, mode_c[i], cvec_c[i]);
        end
    end
    assign exp_res_c = lut(vec_c);

    alu_bist_redundancy_ctrl #(
        .DATA_W(8), .NUM_UNITS(3), .NUM_VECTORS(8), .TEST_PERIOD(16), .FAIL_THRESH(1)
    ) u_c (
        .clk(clk), .rst(rst), .test_req(test_req_c), .unit_res(unit_res_c),
        .unit_carry(unit_carry_c), .exp_res(exp_res_c), .exp_carry(vec_c[0]),
        .test_en(test_en_c), .vec_idx(vec_c), .active_sel(act_c), .out_sel(out_c),
        .stall_req(stall_c), .unit_failed(failed_c), .fault_flag(fault_c),
        .spares_exhausted(spares_c)
    );

    initial begin
        int seen;
        test_req_a = 1'b0;
        test_req_b = 1'b0;
        test_req_c = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mode_a[i] = 2'd0; cvec_a[i] = 3'd0;
            mode_b[i] = 2'd0; cvec_b[i] = 3'd0;
        end
        for (int i = 0; i < 3; i++) begin
            mode_c[i] = 2'd0; cvec_c[i] = 3'd0;
        end

        // ---- A1: asynchronous reset aborts a running session ----
        #12 rst = 1'b1;
        tick();
        test_req_a = 1'b1;
        tick();
        test_req_a = 1'b0;
        check_eq("a_pre_test_en", 32'(test_en_a), 32'd1);
        tick(2);
        check_eq("a_pre_vec", 32'(vec_a), 32'd2);
        #3 rst = 1'b0;
        #1;
        check_eq("a_rst_test_en", 32'(test_en_a), 32'd0);
        check_eq("a_rst_vec", 32'(vec_a), 32'd0);
        check_eq("a_rst_act", 32'(act_a), 32'd0);
        check_eq("a_rst_out", 32'(out_a), 32'd0);
        check_eq("a_rst_stall", 32'(stall_a), 32'd0);
        check_eq("a_rst_failed", 32'(failed_a), 32'd0);
        check_eq("a_rst_fault", 32'(fault_a), 32'd0);
        check_eq("a_rst_spares", 32'(spares_a), 32'd0);
        #2 rst = 1'b1;

        // ---- A2: periodic session, fault-free ----
        tick(15);
        check_eq("a_idle15_test_en", 32'(test_en_a), 32'd0);
        tick();
        check_eq("a_t17_test_en", 32'(test_en_a), 32'd1);
        check_eq("a_t17_vec", 32'(vec_a), 32'd0);
        check_eq("a_t17_out", 32'(out_a), 32'd1);
        check_eq("a_t17_stall", 32'(stall_a), 32'd0);
        for (int k = 1; k < 8; k++) begin
            tick();
            check_eq("a_run_vec", 32'(vec_a), 32'(k));
            check_eq("a_run_test_en", 32'(test_en_a), 32'd1);
        end
        tick();
        check_eq("a_eval_test_en", 32'(test_en_a), 32'd0);
        check_eq("a_eval_out", 32'(out_a), 32'd1);
        tick();
        check_eq("a_idle_out", 32'(out_a), 32'd0);
        check_eq("a_idle_fault", 32'(fault_a), 32'd0);

        // ---- A3: unit 0 result corrupted at vector 3 -> retire, promote unit 1 ----
        mode_a[0] = 2'd1; cvec_a[0] = 3'd3;
        test_req_a = 1'b1;
        tick();
        test_req_a = 1'b0;
        tick(8);
        check_eq("a3_eval_failed", 32'(failed_a), 32'd0);
        tick();
        check_eq("a3_failed", 32'(failed_a), 32'b01);
        check_eq("a3_act", 32'(act_a), 32'd1);
        check_eq("a3_out", 32'(out_a), 32'd1);
        check_eq("a3_fault", 32'(fault_a), 32'd1);
        check_eq("a3_spares", 32'(spares_a), 32'd0);

        // ---- A4: unit 1 carry wrong at vector 7, no cover -> stall, then dead ----
        mode_a[1] = 2'd2; cvec_a[1] = 3'd7;
        test_req_a = 1'b1;
        tick();
        test_req_a = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check_eq("a4_stall", 32'(stall_a), 32'd1);
            check_eq("a4_out", 32'(out_a), 32'd1);
            tick();
        end
        check_eq("a4_eval_stall", 32'(stall_a), 32'd1);
        tick();
        check_eq("a4_spares", 32'(spares_a), 32'd1);
        check_eq("a4_failed", 32'(failed_a), 32'b11);
        check_eq("a4_dead_stall", 32'(stall_a), 32'd0);
        check_eq("a4_dead_out", 32'(out_a), 32'd1);
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            test_req_a = (i % 7 == 0);
            tick();
            if (test_en_a) seen++;
        end
        test_req_a = 1'b0;
        check_eq("a4_dead_quiet", 32'(seen), 32'd0);
        check_eq("a4_dead_spares", 32'(spares_a), 32'd1);

        // ---- B: threshold 2, fail then pass retest; fail counter clears ----
        #3 rst = 1'b0;
        #2 rst = 1'b1;
        mode_b[0] = 2'd1; cvec_b[0] = 3'd2;
        test_req_b = 1'b1;
        tick();
        test_req_b = 1'b0;
        tick(8);
        check_eq("b_eval_test_en", 32'(test_en_b), 32'd0);
        check_eq("b_eval_failed", 32'(failed_b), 32'd0);
        mode_b[0] = 2'd0;
        tick();
        check_eq("b_retest_test_en", 32'(test_en_b), 32'd1);
        check_eq("b_retest_vec", 32'(vec_b), 32'd0);
        tick(8);
        tick();
        check_eq("b_pass_test_en", 32'(test_en_b), 32'd0);
        check_eq("b_pass_failed", 32'(failed_b), 32'd0);
        mode_b[0] = 2'd1;
        test_req_b = 1'b1;
        tick();
        test_req_b = 1'b0;
        tick(8);
        tick();
        check_eq("b_cnt_clr_retest", 32'(test_en_b), 32'd1);
        check_eq("b_cnt_clr_failed", 32'(failed_b), 32'd0);
        tick(8);
        tick();
        check_eq("b_retire_failed", 32'(failed_b), 32'b01);
        check_eq("b_retire_act", 32'(act_b), 32'd1);

        // ---- C: 3 units, test_req at timer 4, request during TEST dropped ----
        #3 rst = 1'b0;
        #2 rst = 1'b1;
        mode_c[0] = 2'd1; cvec_c[0] = 3'd5;
        tick(4);
        check_eq("c_pre_test_en", 32'(test_en_c), 32'd0);
        test_req_c = 1'b1;
        tick();
        test_req_c = 1'b0;
        check_eq("c_req_test_en", 32'(test_en_c), 32'd1);
        check_eq("c_req_out", 32'(out_c), 32'd1);
        check_eq("c_req_act", 32'(act_c), 32'd0);
        tick(3);
        test_req_c = 1'b1;
        tick();
        test_req_c = 1'b0;
        tick(3);
        check_eq("c_vec7", 32'(vec_c), 32'd7);
        tick(2);
        check_eq("c_retire_failed", 32'(failed_c), 32'b001);
        check_eq("c_retire_act", 32'(act_c), 32'd1);
        check_eq("c_retire_out", 32'(out_c), 32'd1);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (test_en_c) seen++;
        end
        check_eq("c_req_dropped", 32'(seen), 32'd0);
        test_req_c = 1'b1;
        tick();
        test_req_c = 1'b0;
        check_eq("c_s2_test_en", 32'(test_en_c), 32'd1);
        check_eq("c_s2_out", 32'(out_c), 32'd2);
        check_eq("c_s2_stall", 32'(stall_c), 32'd0);
        check_eq("c_s2_act", 32'(act_c), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
